// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle sequencer for the MIPS-subset datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and shares one
// memory port between instruction fetch and data access via req/ready.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   opcode              IR[31:26], stable from DECODE onward
//   br_cond             ALU compare result for beq/bne (sampled in EXEC)
//   mem_ready           memory completes the current request this cycle
//   mem_req, mem_we     memory request / write qualifier
//   mem_addr_src        0 = PC, 1 = ALU result register
//   ir_we, pc_we, reg_we  load strobes for IR, PC, register file
//   AluCtrl, s_*        datapath selects (decode selects follow opcode)
//   state               current state for debug
//   trap                illegal opcode seen (sticky until reset)
//   instr_count         retired-instruction counter, wraps
module multicycle_control #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             br_cond,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_src,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic [2:0]       AluCtrl,
    output logic             s_Imext,
    output logic             s_A_src,
    output logic             s_B_src,
    output logic [1:0]       s_PC_src,
    output logic             s_reg_wb_src,
    output logic             s_reg_wb_dst,
    output logic [2:0]       state,
    output logic             trap,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [5:0] OP_R     = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    state_t state_q;
    state_t state_d;
    logic   retire;
    logic   legal;
    logic   is_j;
    logic   is_br;
    logic   is_mem;
    logic   is_sw;

    assign state = state_q;

    // Opcode decode: datapath selects and instruction class flags
    always_comb begin
        legal        = 1'b1;
        AluCtrl      = 3'd0;
        s_Imext      = 1'b0;
        s_A_src      = 1'b0;
        s_B_src      = 1'b1;
        s_reg_wb_src = 1'b0;
        s_reg_wb_dst = 1'b1;
        case (opcode)
            OP_R: begin
                AluCtrl      = 3'd7;
                s_B_src      = 1'b0;
                s_reg_wb_dst = 1'b0;
            end
            OP_J:     AluCtrl = 3'd0;
            OP_BEQ: begin
                AluCtrl = 3'd5;
                s_A_src = 1'b1;
            end
            OP_BNE: begin
                AluCtrl = 3'd6;
                s_A_src = 1'b1;
            end
            OP_ADDI:  AluCtrl = 3'd2;
            OP_SLTI:  AluCtrl = 3'd3;
            OP_SLTIU: AluCtrl = 3'd4;
            OP_ANDI: begin
                AluCtrl = 3'd0;
                s_Imext = 1'b1;
            end
            OP_ORI: begin
                AluCtrl = 3'd1;
                s_Imext = 1'b1;
            end
            OP_LUI:   AluCtrl = 3'd0;
            OP_LW: begin
                AluCtrl      = 3'd2;
                s_reg_wb_src = 1'b1;
            end
            OP_SW:    AluCtrl = 3'd2;
            default:  legal = 1'b0;
        endcase
    end

    assign is_j   = (opcode == OP_J);
    assign is_br  = (opcode == OP_BEQ) || (opcode == OP_BNE);
    assign is_sw  = (opcode == OP_SW);
    assign is_mem = (opcode == OP_LW) || is_sw;

    // Next state and strobes; completion strobes are Mealy on mem_ready
    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_src = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        reg_we       = 1'b0;
        s_PC_src     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!legal) begin
                    state_d = S_TRAP;
                end else if (is_j) begin
                    pc_we    = 1'b1;
                    s_PC_src = 2'b01;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_br) begin
                    if (br_cond) begin
                        pc_we    = 1'b1;
                        s_PC_src = 2'b10;
                    end
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_mem) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_addr_src = 1'b1;
                mem_we       = is_sw;
                if (mem_ready) begin
                    if (is_sw) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        // Reset abandons any access in flight
        if (reset) begin
            mem_req  = 1'b0;
            mem_we   = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            reg_we   = 1'b0;
            s_PC_src = 2'b00;
        end
    end

    // State, sticky trap flag and retired-instruction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            trap        <= 1'b0;
            instr_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == S_TRAP) begin
                trap <= 1'b1;
            end
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: decode table plus a per-cycle scoreboard of
// expected state/strobe records built from instruction descriptions.
module tb_multicycle_control;

    localparam int unsigned CNT_W = 4;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;
    localparam logic [5:0] OP_BAD  = 6'h3f;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       opcode;
    logic             br_cond;
    logic             mem_ready;
    logic             mem_req, mem_we, mem_addr_src, ir_we, pc_we, reg_we;
    logic [2:0]       AluCtrl;
    logic             s_Imext, s_A_src, s_B_src, s_reg_wb_src, s_reg_wb_dst;
    logic [1:0]       s_PC_src;
    logic [2:0]       state;
    logic             trap;
    logic [CNT_W-1:0] instr_count;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .br_cond(br_cond),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_src(mem_addr_src), .ir_we(ir_we), .pc_we(pc_we),
        .reg_we(reg_we), .AluCtrl(AluCtrl), .s_Imext(s_Imext),
        .s_A_src(s_A_src), .s_B_src(s_B_src), .s_PC_src(s_PC_src),
        .s_reg_wb_src(s_reg_wb_src), .s_reg_wb_dst(s_reg_wb_dst),
        .state(state), .trap(trap), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycles = 0;
    logic [CNT_W-1:0] model_cnt = '0;

    // exp = {state, mem_req, mem_we, mem_addr_src, ir_we, pc_we, reg_we, s_PC_src, trap}
    typedef struct packed {
        logic [11:0] exp;
        logic        rdy;
        logic        brc;
    } rec_t;
    rec_t sb[$];

    typedef struct packed {
        logic [5:0] op;
        logic [2:0] alu;
        logic       imx, asrc, bsrc, wsrc, wdst, dst_dc;
    } dec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic req, input logic we,
                        input logic src, input logic ir, input logic pc,
                        input logic rg, input logic [1:0] pcs, input logic trp,
                        input logic rdy, input logic brc);
        rec_t r;
        r.exp = {st, req, we, src, ir, pc, rg, pcs, trp};
        r.rdy = rdy;
        r.brc = brc;
        sb.push_back(r);
    endtask

    function automatic logic is_legal(input logic [5:0] op);
        case (op)
            6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0a, 6'h0b,
            6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Expected per-cycle behaviour of one instruction; fw/mw are wait cycles
    task automatic build(input logic [5:0] op, input int fw, input int mw, input logic brc);
        logic sw;
        sw = (op == OP_SW);
        for (int i = 0; i < fw; i++) push(3'd0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        push(3'd0, 1, 0, 0, 1, 1, 0, 2'b00, 0, 1, 0);
        if (!is_legal(op)) begin
            push(3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
            for (int i = 0; i < 10; i++) push(3'd5, 0, 0, 0, 0, 0, 0, 2'b00, 1, 1, 1);
            return;
        end
        if (op == OP_J) begin
            push(3'd1, 0, 0, 0, 0, 1, 0, 2'b01, 0, 1, 0);
            model_cnt++;
            return;
        end
        push(3'd1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 0);
        if (op == OP_BEQ || op == OP_BNE) begin
            push(3'd2, 0, 0, 0, 0, brc, 0, brc ? 2'b10 : 2'b00, 0, 1, brc);
            model_cnt++;
            return;
        end
        push(3'd2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 1);
        if (op == OP_LW || sw) begin
            for (int i = 0; i < mw; i++) push(3'd3, 1, sw, 1, 0, 0, 0, 2'b00, 0, 0, 0);
            push(3'd3, 1, sw, 1, 0, 0, 0, 2'b00, 0, 1, 0);
            if (sw) begin
                model_cnt++;
                return;
            end
        end
        push(3'd4, 0, 0, 0, 0, 0, 1, 2'b00, 0, 1, 0);
        model_cnt++;
    endtask

    // Pop up to n records: drive, check away from the edge, advance one cycle
    task automatic run_n(input int n);
        rec_t r;
        for (int i = 0; i < n && sb.size() > 0; i++) begin
            r = sb.pop_front();
            mem_ready = r.rdy;
            br_cond   = r.brc;
            #1;
            chk($sformatf("cycle%0d", cycles),
                32'({state, mem_req, mem_we, mem_addr_src, ir_we, pc_we, reg_we, s_PC_src, trap}),
                32'(r.exp));
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic brc);
        opcode = op;
        build(op, fw, mw, brc);
        run_n(1000);
        chk($sformatf("count_op%0h", op), 32'(instr_count), 32'(model_cnt));
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_cnt = '0;
        #1;
        chk("rst_state", 32'({state, trap}), 32'(0));
        chk("rst_count", 32'(instr_count), 32'(0));
    endtask

    dec_t dec_tbl[11];

    initial begin
        dec_tbl[0]  = '{6'h00, 3'd7, 0, 0, 0, 0, 0, 0};
        dec_tbl[1]  = '{6'h04, 3'd5, 0, 1, 1, 0, 1, 1};
        dec_tbl[2]  = '{6'h05, 3'd6, 0, 1, 1, 0, 1, 1};
        dec_tbl[3]  = '{6'h08, 3'd2, 0, 0, 1, 0, 1, 0};
        dec_tbl[4]  = '{6'h0a, 3'd3, 0, 0, 1, 0, 1, 0};
        dec_tbl[5]  = '{6'h0b, 3'd4, 0, 0, 1, 0, 1, 0};
        dec_tbl[6]  = '{6'h0c, 3'd0, 1, 0, 1, 0, 1, 0};
        dec_tbl[7]  = '{6'h0d, 3'd1, 1, 0, 1, 0, 1, 0};
        dec_tbl[8]  = '{6'h0f, 3'd0, 0, 0, 1, 0, 1, 0};
        dec_tbl[9]  = '{6'h23, 3'd2, 0, 0, 1, 1, 1, 0};
        dec_tbl[10] = '{6'h2b, 3'd2, 0, 0, 1, 0, 1, 1};

        reset = 1'b1; opcode = OP_R; br_cond = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_strobes_forced", 32'({mem_req, mem_we, ir_we, pc_we, reg_we, s_PC_src}), 32'(0));
        chk("rst_regs", 32'({state, trap, instr_count}), 32'(0));

        // Decode selects are combinational from opcode
        for (int i = 0; i < 11; i++) begin
            opcode = dec_tbl[i].op;
            #1;
            chk($sformatf("dec_%0h", dec_tbl[i].op),
                32'({AluCtrl, s_Imext, s_A_src, s_B_src, s_reg_wb_src,
                     s_reg_wb_dst | dec_tbl[i].dst_dc}),
                32'({dec_tbl[i].alu, dec_tbl[i].imx, dec_tbl[i].asrc,
                     dec_tbl[i].bsrc, dec_tbl[i].wsrc,
                     dec_tbl[i].wdst | dec_tbl[i].dst_dc}));
        end

        // Program with mem_ready tied high, reset released at cycle 0
        @(negedge clk);
        do_reset();
        cycles = 0;
        run_instr(OP_R,    0, 0, 0);
        run_instr(OP_ADDI, 0, 0, 0);
        run_instr(OP_LW,   0, 0, 0);
        run_instr(OP_SW,   0, 0, 0);
        run_instr(OP_BEQ,  0, 0, 1);
        run_instr(OP_J,    0, 0, 0);
        chk("prog_cycles", 32'(cycles), 32'd22);
        chk("prog_count", 32'(instr_count), 32'd6);

        // Fetch wait 3, then lw data wait 2
        run_instr(OP_LW, 3, 2, 0);

        // Branch not taken then taken
        run_instr(OP_BEQ, 0, 0, 0);
        run_instr(OP_BNE, 0, 0, 1);

        // Illegal opcode: trap held with no strobes, reset recovers
        run_instr(OP_BAD, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("trap_rst_strobes", 32'({mem_req, mem_we, ir_we, pc_we, reg_we}), 32'(0));
        @(negedge clk);
        do_reset();

        // Reset during the MEM wait of sw
        run_instr(OP_ADDI, 0, 0, 0);
        opcode = OP_SW;
        build(OP_SW, 0, 5, 0);
        run_n(5);
        sb.delete();
        chk("sw_in_mem", 32'({state, mem_req, mem_we, mem_addr_src}), 32'({3'd3, 3'b111}));
        reset     = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("sw_rst_forced", 32'({mem_req, mem_we}), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        model_cnt = '0;
        #1;
        chk("sw_rst_after", 32'({state, mem_we, instr_count}), 32'(0));
        run_instr(OP_ADDI, 1, 0, 0);

        // Counter wrap at 2^CNT_W - 1
        for (int i = 0; i < 14; i++) run_instr(OP_J, 0, 0, 0);
        chk("count_full", 32'(instr_count), 32'd15);
        run_instr(OP_J, 0, 0, 0);
        chk("count_wrap", 32'(instr_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle sequencer for the MIPS-subset datapath. It replaces purely combinational per-instruction control with a state machine that steps each instruction through fetch, decode, execute, memory and write-back. It shares one memory port between instruction fetch and data access using a req/ready handshake. The datapath select encodings are unchanged, so ALU, muxes and register file connect directly.

## Interface
- `CNT_W`, default 32: width of retired-instruction counter.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; stable from DECODE onward (IR loads only on `ir_we`).
- `br_cond`  in  1  ALU compare result in EXEC for beq/bne (1 = taken).
- `mem_ready`  in  1  memory completes current request this cycle.
- `mem_req`  out  1  memory access request.
- `mem_we`  out  1  write request (valid with `mem_req`).
- `mem_addr_src`  out  1  0 = PC, 1 = ALU result register.
- `ir_we`, `pc_we`, `reg_we`  out  1 each  load strobes for IR, PC and register file.
- `AluCtrl`  out  3  and 0, or 1, add 2, slt 3, sltu 4, beq 5, bne 6, R-type 7 (funct-decoded in ALU).
- `s_Imext`  out  1  1 = zero-extend imm (andi/ori), else sign-extend.
- `s_A_src`  out  1  1 for beq/bne.
- `s_B_src`  out  1  1 = immediate (all non-R).
- `s_PC_src`  out  2  00 PC+4, 01 jump, 10 branch target.
- `s_reg_wb_src`  out  1  1 = memory data (lw).
- `s_reg_wb_dst`  out  1  1 = rt, 0 = rd.
- `state`  out  3  current state, for debug.
- `trap`  out  1  illegal opcode seen.
- `instr_count`  out  CNT_W  retired instructions.

## Operation
- Legal opcodes: 0x00 R, 0x02 j, 0x04 beq, 0x05 bne, 0x08 addi, 0x0a slti, 0x0b sltiu, 0x0c andi, 0x0d ori, 0x0f lui (AluCtrl 0), 0x23 lw, 0x2b sw.
- AluCtrl encoding: add is used for addi, lw and sw.
- Decode selects (`AluCtrl`, `s_Imext`, `s_A_src`, `s_B_src`, `s_reg_wb_src`, `s_reg_wb_dst`) are combinational from `opcode`. They are meaningful in EXEC/MEM/WB.
- Strobes (`mem_req`, `mem_we`, `ir_we`, `pc_we`, `reg_we`) and `s_PC_src` are functions of state, `mem_ready` and `br_cond`. They are 0, or 00 for `s_PC_src`, unless listed below.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to FETCH.
- FETCH:
  - `mem_req`=1, `mem_addr_src`=0.
  - On `mem_ready`: `ir_we`=1, `pc_we`=1, `s_PC_src`=00, then go to DECODE. Otherwise stay.
- DECODE:
  - Illegal opcode: go to TRAP.
  - j: `pc_we`=1, `s_PC_src`=01, retire, go to FETCH.
  - All others: go to EXEC.
- EXEC:
  - beq/bne: if `br_cond`, `pc_we`=1 and `s_PC_src`=10. Retire and go to FETCH.
  - lw/sw: go to MEM.
  - All others: go to WB.
- MEM:
  - `mem_req`=1, `mem_addr_src`=1, `mem_we`=1 for sw.
  - On `mem_ready`: sw retires and goes to FETCH; lw goes to WB. Otherwise stay.
- WB: `reg_we`=1, retire, go to FETCH.
- TRAP: `trap`=1, all strobes 0; held until reset.
- `mem_ready` outside FETCH/MEM is ignored.
- Retire: `instr_count` += 1 at the clock edge ending the instruction's last state. It wraps modulo 2^CNT_W.

## Timing
- Reset values: state FETCH, `instr_count` 0, `trap` 0.
- While `reset` is high, all strobes are forced to 0 combinationally. Reset mid-access abandons the access; the memory must tolerate `mem_req` dropping without `mem_ready`.
- Handshake:
  - `mem_req`, `mem_we` and `mem_addr_src` stay asserted and stable from assertion until the cycle `mem_ready` is high.
  - Completion and the associated strobe (`ir_we`/`pc_we`) occur in that same cycle, which is a Mealy path on `mem_ready`.
  - The next request starts no earlier than the following cycle.
- Latency with `mem_ready` tied high: j 2 cycles, beq/bne 3, R/imm/lui 4, sw 4, lw 5. Each wait cycle adds 1.
- FETCH updates PC to PC+4 before EXEC. The branch target is relative to the incremented PC.
- `br_cond` is sampled only in EXEC.

## Test plan
- `mem_ready`=1, program R-type, addi, lw, sw, beq(taken), j, with `reset` released at cycle 0 -> state trace 0,1,2,4 / 0,1,2,4 / 0,1,2,3,4 / 0,1,2,3 / 0,1,2 / 0,1. `instr_count`=6 after 22 cycles. `reg_we` pulses only in WB.
- Fetch wait of 3 cycles, then lw with data wait of 2 -> `mem_req` high 4 cycles with `mem_addr_src`=0, then 3 cycles with 1. `ir_we` and `pc_we` are single pulses coincident with `mem_ready`.
- beq with `br_cond`=0, then bne with `br_cond`=1 -> the first has no `pc_we` in EXEC. The second has `pc_we`=1, `s_PC_src`=10, `AluCtrl`=6.
- opcode 0x3f in DECODE -> `state`=5, `trap`=1, no strobes for 10 cycles. `reset` returns to FETCH with `instr_count`=0.
- `reset` asserted during MEM wait of sw -> next cycle `state`=0, `mem_we`=0, `instr_count`=0. A subsequent fetch proceeds normally.
- Preload count 2^CNT_W−1 (CNT_W=4), retire one -> `instr_count`=0.
